// File: rtl/xc_malu_pkg.sv
// Shared definitions for the xc_malu arbiter slice.
//  - xc_malu opcode indices (index = bit position in the one-hot uop vector)
//  - number of legal uops
//  - one-hot FSM state encoding used by xc_malu_arbiter
package xc_malu_pkg;

  localparam int XC_MALU_OP_DIV    = 0;
  localparam int XC_MALU_OP_DIVU   = 1;
  localparam int XC_MALU_OP_REM    = 2;
  localparam int XC_MALU_OP_REMU   = 3;
  localparam int XC_MALU_OP_MUL    = 4;
  localparam int XC_MALU_OP_MULU   = 5;
  localparam int XC_MALU_OP_MULH   = 6;
  localparam int XC_MALU_OP_MULHU  = 7;
  localparam int XC_MALU_OP_MULHSU = 8;
  localparam int XC_MALU_OP_CLMUL  = 9;
  localparam int XC_MALU_OP_CLMULH = 10;
  localparam int XC_MALU_OP_CLMULR = 11;
  localparam int XC_MALU_OP_PMUL   = 12;
  localparam int XC_MALU_OP_MMUL   = 13;

  localparam int XC_MALU_NUOP = 14;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_BUSY  = 4'b0010,
    ST_RESP  = 4'b0100,
    ST_FLUSH = 4'b1000
  } arb_state_t;

  // Opcodes at or beyond XC_MALU_NUOP have no xc_malu uop behind them.
  function automatic logic op_is_legal(input int unsigned op);
    return op < XC_MALU_NUOP;
  endfunction

endpackage

// File: rtl/xc_malu_rr_arb.sv
// Combinational round-robin arbiter.
//  req       in   NREQ    request vector
//  ptr       in   PTR_W   highest-priority index (must be < NREQ)
//  grant     out  NREQ    one-hot grant (zero when no request)
//  grant_idx out  PTR_W   binary index of the granted requester
//  any       out  1       at least one request present
module xc_malu_rr_arb #(
  parameter int NREQ  = 2,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  int  pos;
  logic found;

  // Scan from ptr upwards, wrapping, and take the first requester seen.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr) + k) % NREQ;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        grant_idx  = PTR_W'(pos);
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/xc_malu_arbiter.sv
// Shares one xc_malu between NREQ requesters.
// Round-robin grant in IDLE, latches the winner's op/pw/operands, drives xc_malu
// until malu_ready, returns the 64-bit result to the owner, then flushes xc_malu.
//  clock, resetn                 clock and synchronous active-low reset
//  req_valid/req_ready           per-requester request handshake (ready only in IDLE)
//  req_op/req_pw/req_rs1..3      packed per-requester opcode, pack width, operands
//  req_kill                      owner cancels its in-flight op
//  rsp_valid/rsp_ready           per-requester response handshake
//  rsp_result/rsp_err            response payload
//  malu_*                        xc_malu operand/uop/control outputs, result/ready inputs
module xc_malu_arbiter
  import xc_malu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int OP_W = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_op,
  input  logic [NREQ*5-1:0]    req_pw,
  input  logic [NREQ*32-1:0]   req_rs1,
  input  logic [NREQ*32-1:0]   req_rs2,
  input  logic [NREQ*32-1:0]   req_rs3,
  input  logic [NREQ-1:0]      req_kill,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [63:0]          rsp_result,
  output logic                 rsp_err,
  output logic [31:0]          malu_rs1,
  output logic [31:0]          malu_rs2,
  output logic [31:0]          malu_rs3,
  output logic [13:0]          malu_uop,
  output logic [4:0]           malu_pw,
  output logic                 malu_valid,
  output logic                 malu_flush,
  input  logic [63:0]          malu_result,
  input  logic                 malu_ready
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic [OP_W-1:0]  op;
  logic [4:0]       pw;
  logic [31:0]      rs1, rs2, rs3;
  logic [63:0]      result;
  logic             err;

  logic [OP_W-1:0]  op_arr  [NREQ];
  logic [4:0]       pw_arr  [NREQ];
  logic [31:0]      rs1_arr [NREQ];
  logic [31:0]      rs2_arr [NREQ];
  logic [31:0]      rs3_arr [NREQ];
  logic [NREQ-1:0]  owner_hot;

  logic [NREQ-1:0]  grant;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_any;
  logic [PTR_W-1:0] ptr_after;
  logic             owner_kill;
  logic             owner_ack;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op_arr[gi]    = req_op[gi*OP_W +: OP_W];
      assign pw_arr[gi]    = req_pw[gi*5 +: 5];
      assign rs1_arr[gi]   = req_rs1[gi*32 +: 32];
      assign rs2_arr[gi]   = req_rs2[gi*32 +: 32];
      assign rs3_arr[gi]   = req_rs3[gi*32 +: 32];
      assign owner_hot[gi] = (owner == PTR_W'(gi));
    end
  endgenerate

  xc_malu_rr_arb #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign ptr_after  = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PTR_W'(1);
  // Only the owner's kill / rsp_ready lines matter; others are masked here.
  assign owner_kill = |(req_kill & owner_hot);
  assign owner_ack  = |(rsp_ready & owner_hot);

  // Grant is combinational so the winner sees req_ready in its request cycle;
  // held off while in reset so nothing is accepted that the FSM would drop.
  assign req_ready  = (state == ST_IDLE && resetn) ? grant : '0;
  assign rsp_valid  = (state == ST_RESP) ? owner_hot : '0;
  assign rsp_err    = (state == ST_RESP) && err;
  assign rsp_result = result;
  assign malu_valid = (state == ST_BUSY);
  assign malu_flush = (state == ST_FLUSH);
  assign malu_rs1   = rs1;
  assign malu_rs2   = rs2;
  assign malu_rs3   = rs3;
  assign malu_pw    = pw;

  // One-hot uop only while BUSY so xc_malu never sees a stale uop.
  always_comb begin
    malu_uop = '0;
    if (state == ST_BUSY) begin
      for (int i = 0; i < XC_MALU_NUOP; i++) begin
        malu_uop[i] = (int'(op) == i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      owner  <= '0;
      op     <= '0;
      pw     <= '0;
      rs1    <= '0;
      rs2    <= '0;
      rs3    <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            owner  <= grant_idx;
            op     <= op_arr[grant_idx];
            pw     <= pw_arr[grant_idx];
            rs1    <= rs1_arr[grant_idx];
            rs2    <= rs2_arr[grant_idx];
            rs3    <= rs3_arr[grant_idx];
            ptr    <= ptr_after;
            result <= '0;
            if (op_is_legal(int'(op_arr[grant_idx]))) begin
              err   <= 1'b0;
              state <= ST_BUSY;
            end else begin
              // No uop exists: answer directly with an error, xc_malu untouched.
              err   <= 1'b1;
              state <= ST_RESP;
            end
          end
        end
        ST_BUSY: begin
          if (owner_kill) begin
            state <= ST_FLUSH;
          end else if (malu_ready) begin
            result <= malu_result;
            state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (owner_kill || owner_ack) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xc_malu_arbiter.sv
module tb_xc_malu_arbiter;

  localparam int NREQ = 2;
  localparam int OP_W = 4;

  logic                 clock = 1'b0;
  logic                 resetn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OP_W-1:0] req_op;
  logic [NREQ*5-1:0]    req_pw;
  logic [NREQ*32-1:0]   req_rs1, req_rs2, req_rs3;
  logic [NREQ-1:0]      req_kill;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [63:0]          rsp_result;
  logic                 rsp_err;
  logic [31:0]          malu_rs1, malu_rs2, malu_rs3;
  logic [13:0]          malu_uop;
  logic [4:0]           malu_pw;
  logic                 malu_valid, malu_flush;
  logic [63:0]          malu_result;
  logic                 malu_ready;

  int checks = 0;
  int errors = 0;

  xc_malu_arbiter #(.NREQ(NREQ), .OP_W(OP_W)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_pw(req_pw),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_kill(req_kill),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3), .malu_uop(malu_uop),
    .malu_pw(malu_pw), .malu_valid(malu_valid), .malu_flush(malu_flush),
    .malu_result(malu_result), .malu_ready(malu_ready)
  );

  always #5 clock = ~clock;

  // Tiny xc_malu stand-in: ready on the 3rd consecutive valid cycle.
  // uop bit 0 (div) returns {rem, quot}; everything else returns rs1*rs2.
  int malu_cnt = 0;
  always @(posedge clock) begin
    if (!malu_valid) malu_cnt <= 0;
    else             malu_cnt <= malu_cnt + 1;
  end
  assign malu_ready = malu_valid && (malu_cnt == 2);
  always_comb begin
    malu_result = 64'd0;
    if (malu_uop[0]) begin
      if (malu_rs2 != 0) malu_result = {malu_rs1 % malu_rs2, malu_rs1 / malu_rs2};
    end else begin
      malu_result = {32'd0, malu_rs1} * {32'd0, malu_rs2};
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int who, input int op, input logic [31:0] a, input logic [31:0] b);
    req_op[who*OP_W +: OP_W] = OP_W'(op);
    req_pw[who*5 +: 5]       = 5'b00001;
    req_rs1[who*32 +: 32]    = a;
    req_rs2[who*32 +: 32]    = b;
    req_rs3[who*32 +: 32]    = 32'd0;
  endtask

  task automatic wait_rsp(input int who, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid[who]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready != 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req_valid = '0; req_kill = '0; rsp_ready = '0;
    req_op = '0; req_pw = '0; req_rs1 = '0; req_rs2 = '0; req_rs3 = '0;
    do_reset();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
    checks++; if (malu_valid !== 1'b0 || malu_flush !== 1'b0) begin errors++; $display("FAIL reset_malu_ctrl got v=%b f=%b want 0 0", malu_valid, malu_flush); end
    checks++; if (malu_uop !== 14'd0 || rsp_result !== 64'd0 || malu_rs1 !== 32'd0) begin errors++; $display("FAIL reset_data got uop=%h res=%h rs1=%h want 0", malu_uop, rsp_result, malu_rs1); end
    $display("reset done");
  endtask

  task automatic test_basic();
    bit ok;
    set_req(0, 5, 32'd3, 32'd7);
    req_valid = 2'b01; rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL basic_grant got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (malu_valid !== 1'b1 || malu_uop !== 14'h0020 || malu_rs1 !== 32'd3 || malu_rs2 !== 32'd7) begin
      errors++; $display("FAIL basic_busy got v=%b uop=%h rs1=%0d rs2=%0d want 1 0020 3 7", malu_valid, malu_uop, malu_rs1, malu_rs2); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL basic_busy_ready got %b want 00", req_ready); end
    wait_rsp(0, ok);
    checks++; if (!ok || rsp_valid !== 2'b01 || rsp_result !== 64'd21 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL basic_rsp got ok=%0d v=%b res=%0d err=%b want 1 01 21 0", ok, rsp_valid, rsp_result, rsp_err); end
    $display("op req0 mulu 3*7 -> %0d", rsp_result);
    tick();
    checks++; if (malu_flush !== 1'b1 || malu_valid !== 1'b0 || rsp_valid !== 2'b00) begin
      errors++; $display("FAIL basic_flush got f=%b v=%b rv=%b want 1 0 00", malu_flush, malu_valid, rsp_valid); end
    tick();
    checks++; if (malu_flush !== 1'b0) begin errors++; $display("FAIL basic_flush_once got %b want 0", malu_flush); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0] exp;
    do_reset();
    set_req(0, 5, 32'd2, 32'd3);
    set_req(1, 5, 32'd4, 32'd5);
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    for (int n = 0; n < 4; n++) begin
      exp = (n % 2 == 0) ? 2'b01 : 2'b10;
      wait_grant(ok);
      checks++; if (!ok || req_ready !== exp) begin errors++; $display("FAIL rr_grant%0d got %b want %b", n, req_ready, exp); end
      $display("rr grant %0d -> %b", n, req_ready);
      tick();
      if (n == 3) req_valid = 2'b00;
    end
    wait_rsp(1, ok);
    checks++; if (!ok || rsp_result !== 64'd20) begin errors++; $display("FAIL rr_last_rsp got ok=%0d res=%0d want 1 20", ok, rsp_result); end
    tick();
    tick();
  endtask

  task automatic test_illegal();
    bit ok;
    set_req(1, 15, 32'd9, 32'd9);
    req_valid = 2'b10; rsp_ready = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL illegal_grant got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_result !== 64'd0) begin
      errors++; $display("FAIL illegal_rsp got v=%b err=%b res=%h want 10 1 0", rsp_valid, rsp_err, rsp_result); end
    checks++; if (malu_valid !== 1'b0 || malu_uop !== 14'd0) begin errors++; $display("FAIL illegal_malu_valid got %b uop=%h want 0 0", malu_valid, malu_uop); end
    $display("op req1 op15 -> err=%b", rsp_err);
    rsp_ready = 2'b10;
    tick();
    checks++; if (malu_flush !== 1'b1 || malu_valid !== 1'b0) begin errors++; $display("FAIL illegal_flush got f=%b v=%b want 1 0", malu_flush, malu_valid); end
    tick();
    ok = 1'b1;
  endtask

  task automatic test_kill();
    bit ok;
    set_req(0, 0, 32'd100, 32'd7);
    req_valid = 2'b01; rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL kill_grant got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    checks++; if (malu_valid !== 1'b1) begin errors++; $display("FAIL kill_busy3 got %b want 1", malu_valid); end
    req_kill = 2'b01;
    tick();
    req_kill = 2'b00;
    checks++; if (malu_flush !== 1'b1 || rsp_valid !== 2'b00 || malu_valid !== 1'b0) begin
      errors++; $display("FAIL kill_flush got f=%b rv=%b v=%b want 1 00 0", malu_flush, rsp_valid, malu_valid); end
    tick();
    checks++; if (malu_flush !== 1'b0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL kill_idle got f=%b rv=%b want 0 00", malu_flush, rsp_valid); end
    $display("op req0 div killed");
    set_req(1, 0, 32'd100, 32'd7);
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL kill_next_grant got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    wait_rsp(1, ok);
    checks++; if (!ok || rsp_result[31:0] !== 32'd14) begin errors++; $display("FAIL kill_next_div got ok=%0d lo=%0d want 1 14", ok, rsp_result[31:0]); end
    $display("op req1 div 100/7 -> %0d", rsp_result[31:0]);
    tick();
    tick();
  endtask

  task automatic test_hold();
    bit ok;
    set_req(0, 5, 32'd9, 32'd9);
    req_valid = 2'b01; rsp_ready = 2'b00;
    #1;
    tick();
    set_req(1, 5, 32'd1, 32'd1);
    req_valid = 2'b10;
    wait_rsp(0, ok);
    checks++; if (!ok || rsp_result !== 64'd81) begin errors++; $display("FAIL hold_first got ok=%0d res=%0d want 1 81", ok, rsp_result); end
    // Other requester pokes kill and rsp_ready: both must be ignored.
    req_kill = 2'b10; rsp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (rsp_valid !== 2'b01 || rsp_result !== 64'd81) begin errors++; $display("FAIL hold_stable%0d got v=%b res=%0d want 01 81", i, rsp_valid, rsp_result); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL hold_ready%0d got %b want 00", i, req_ready); end
    end
    req_kill = 2'b00; rsp_ready = 2'b01;
    tick();
    checks++; if (malu_flush !== 1'b1) begin errors++; $display("FAIL hold_flush got %b want 1", malu_flush); end
    $display("op req0 held 10 cycles -> %0d", rsp_result);
    tick();
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL hold_next_grant got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00; rsp_ready = 2'b11;
    wait_rsp(1, ok);
    checks++; if (!ok || rsp_result !== 64'd1) begin errors++; $display("FAIL hold_next_rsp got ok=%0d res=%0d want 1 1", ok, rsp_result); end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_req(0, 5, 32'd11, 32'd13);
    req_valid = 2'b01; rsp_ready = 2'b11;
    #1;
    tick();
    req_valid = 2'b00;
    checks++; if (malu_valid !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b want 1", malu_valid); end
    resetn = 1'b0;
    tick();
    checks++; if (malu_valid !== 1'b0 || malu_flush !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      errors++; $display("FAIL rstmid_ctrl got v=%b f=%b rv=%b rr=%b want 0 0 00 00", malu_valid, malu_flush, rsp_valid, req_ready); end
    checks++; if (malu_rs1 !== 32'd0 || malu_uop !== 14'd0 || rsp_result !== 64'd0 || malu_pw !== 5'd0) begin
      errors++; $display("FAIL rstmid_data got rs1=%h uop=%h res=%h pw=%h want 0", malu_rs1, malu_uop, rsp_result, malu_pw); end
    resetn = 1'b1;
    tick();
    set_req(0, 5, 32'd6, 32'd7);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_grant got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    wait_rsp(0, ok);
    checks++; if (!ok || rsp_result !== 64'd42) begin errors++; $display("FAIL rstmid_mul got ok=%0d res=%0d want 1 42", ok, rsp_result); end
    $display("op req0 mul 6*7 after reset -> %0d", rsp_result);
    tick();
    tick();
  endtask

  initial begin
    resetn = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_illegal();
    test_kill();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
